menshen_axil_regs: RTL and testbench

- AXI4-Lite responder (slave) giving the control plane access to the user-box registers.
- Receives the register writes and reads that the host/QDMA side issues.
  - Example: writing 0x00000001 to address 0x00001000 enables the pipeline.
- Exposes a bank of read/write control registers and a bank of read-only status registers.
- Sits on the axil_aclk domain between the shell's AXI-Lite crossbar and the packet-pipeline configuration logic.

---
 rtl/menshen_axil_pkg.sv | 31 +++
 rtl/menshen_axil_addr_dec.sv | 35 +++
 rtl/menshen_axil_regs.sv | 197 +++++++++++++++++++
 tb/tb_menshen_axil_regs.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/menshen_axil_pkg.sv
// Shared types for the menshen AXI4-Lite register block: response codes, channel
// FSM states, the address-decode result and the byte-strobe merge helper.
package menshen_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int IDX_W = 8;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  typedef enum logic [1:0] {CTRL, STAT, UNMAPPED} region_t;

  typedef struct packed {
    region_t          region;
    logic [IDX_W-1:0] idx;
  } dec_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/menshen_axil_addr_dec.sv
// Combinational byte-address to region/index decoder; zero latency, no flow control.
// addr[1:0] drop out of the shift, so sub-word offsets alias onto the same register.
module menshen_axil_addr_dec
  import menshen_axil_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned           NUM_CTRL   = 8,
  parameter int unsigned           NUM_STAT   = 4
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output dec_t                  o_dec
);

  logic [ADDR_WIDTH-1:0] w_delta;
  logic [ADDR_WIDTH-1:0] w_off;

  assign w_delta = i_addr - BASE_ADDR;
  assign w_off   = w_delta >> 2;

  always_comb begin
    o_dec.region = UNMAPPED;
    o_dec.idx    = '0;
    if (i_addr >= BASE_ADDR) begin
      if (w_off < ADDR_WIDTH'(NUM_CTRL)) begin
        o_dec.region = CTRL;
        o_dec.idx    = IDX_W'(w_off);
      end else if (w_off < ADDR_WIDTH'(NUM_CTRL + NUM_STAT)) begin
        o_dec.region = STAT;
        o_dec.idx    = IDX_W'(w_off - ADDR_WIDTH'(NUM_CTRL));
      end
    end
  end

endmodule

// File: rtl/menshen_axil_regs.sv
// AXI4-Lite RW control / RO status bank; read latency 1, write commits 1 edge after AW+W, one write and one read outstanding.
// MENSHEN_AXIL_WSTRB_EN adds s_axil_wstrb byte-lane masking of control writes; otherwise writes update all 32 bits.
module menshen_axil_regs
  import menshen_axil_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned           NUM_CTRL   = 8,
  parameter int unsigned           NUM_STAT   = 4
) (
  input  logic                       axil_aclk,
  input  logic                       axil_aresetn,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [ADDR_WIDTH-1:0]      s_axil_awaddr,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  input  logic [DATA_WIDTH-1:0]      s_axil_wdata,
`ifdef MENSHEN_AXIL_WSTRB_EN
  input  logic [3:0]                 s_axil_wstrb,
`endif
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  output logic [1:0]                 s_axil_bresp,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  input  logic [ADDR_WIDTH-1:0]      s_axil_araddr,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,
  output logic [DATA_WIDTH-1:0]      s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic [NUM_CTRL*32-1:0]     ctrl_regs,
  output logic [NUM_CTRL-1:0]        ctrl_wr_pulse,
  input  logic [NUM_STAT*32-1:0]     stat_in
);

  wr_state_t             r_wr_state, w_wr_next;
  rd_state_t             r_rd_state, w_rd_next;
  logic                  r_live;
  logic                  r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]           r_wdata;
  logic [1:0]            r_bresp, r_rresp;
  logic [31:0]           r_rdata;
  logic [31:0]           r_ctrl [NUM_CTRL];
  logic [NUM_CTRL-1:0]   r_wr_pulse;

  logic                  w_awready, w_wready, w_arready, w_commit;
  logic                  w_aw_hs, w_w_hs, w_ar_hs;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [31:0]           w_wr_data, w_rd_data;
  dec_t                  w_wr_dec, w_rd_dec;

`ifdef MENSHEN_AXIL_WSTRB_EN
  logic [3:0]            r_wstrb;
  logic [3:0]            w_wr_strb;
  assign w_wr_strb = r_w_held ? r_wstrb : s_axil_wstrb;
`endif

  // A beat handshaking in the commit cycle is used directly, never parked.
  assign w_aw_hs   = s_axil_awvalid && w_awready;
  assign w_w_hs    = s_axil_wvalid && w_wready;
  assign w_ar_hs   = s_axil_arvalid && w_arready;
  assign w_wr_addr = r_aw_held ? r_awaddr : s_axil_awaddr;
  assign w_wr_data = r_w_held ? r_wdata : s_axil_wdata;

  menshen_axil_addr_dec #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR),
                          .NUM_CTRL(NUM_CTRL), .NUM_STAT(NUM_STAT))
    u_aw_dec (.i_addr(w_wr_addr), .o_dec(w_wr_dec));

  menshen_axil_addr_dec #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR),
                          .NUM_CTRL(NUM_CTRL), .NUM_STAT(NUM_STAT))
    u_ar_dec (.i_addr(s_axil_araddr), .o_dec(w_rd_dec));

  always_comb begin
    w_wr_next = r_wr_state;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_commit  = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        w_awready = r_live && !r_aw_held;
        w_wready  = r_live && !r_w_held;
        w_commit  = (r_aw_held || (s_axil_awvalid && w_awready)) &&
                    (r_w_held || (s_axil_wvalid && w_wready));
        if (w_commit) w_wr_next = W_RESP;
      end
      W_RESP:  if (s_axil_bready) w_wr_next = W_IDLE;
      default: w_wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_next = r_rd_state;
    w_arready = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        w_arready = r_live;
        if (s_axil_arvalid && w_arready) w_rd_next = R_DATA;
      end
      R_DATA:  if (s_axil_rready) w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (w_rd_dec.region == CTRL && w_rd_dec.idx == IDX_W'(i)) w_rd_data = r_ctrl[i];
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (w_rd_dec.region == STAT && w_rd_dec.idx == IDX_W'(j)) w_rd_data = stat_in[j*32 +: 32];
    end
  end

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      r_wr_state <= W_IDLE;
      r_rd_state <= R_IDLE;
      r_live     <= 1'b0;
    end else begin
      r_wr_state <= w_wr_next;
      r_rd_state <= w_rd_next;
      r_live     <= 1'b1;
    end
  end

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
`ifdef MENSHEN_AXIL_WSTRB_EN
      r_wstrb    <= '0;
`endif
      for (int i = 0; i < NUM_CTRL; i++) r_ctrl[i] <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bresp   <= (w_wr_dec.region == CTRL) ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (w_wr_dec.region == CTRL && w_wr_dec.idx == IDX_W'(i)) begin
`ifdef MENSHEN_AXIL_WSTRB_EN
            r_ctrl[i] <= apply_wstrb(r_ctrl[i], w_wr_data, w_wr_strb);
`else
            r_ctrl[i] <= w_wr_data;
`endif
            r_wr_pulse[i] <= 1'b1;
          end
        end
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= s_axil_awaddr;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= s_axil_wdata;
`ifdef MENSHEN_AXIL_WSTRB_EN
          r_wstrb  <= s_axil_wstrb;
`endif
        end
      end
    end
  end

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_data;
      r_rresp <= (w_rd_dec.region == UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign s_axil_awready = w_awready;
  assign s_axil_wready  = w_wready;
  assign s_axil_bvalid  = (r_wr_state == W_RESP);
  assign s_axil_bresp   = r_bresp;
  assign s_axil_arready = w_arready;
  assign s_axil_rvalid  = (r_rd_state == R_DATA);
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;
  assign ctrl_wr_pulse  = r_wr_pulse;

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_flat
    assign ctrl_regs[g*32 +: 32] = r_ctrl[g];
  end

endmodule

// File: tb/tb_menshen_axil_regs.sv
// Directed bench for menshen_axil_regs: hand-computed expectations for writes, reads,
// decode boundaries, response backpressure, read/write ordering and mid-write reset.
module tb_menshen_axil_regs;
  localparam int NC = 8;
  localparam int NS = 4;

  logic              axil_aclk = 1'b0;
  logic              axil_aresetn = 1'b0;
  logic              s_axil_awvalid = 1'b0, s_axil_awready;
  logic [31:0]       s_axil_awaddr = '0;
  logic              s_axil_wvalid = 1'b0, s_axil_wready;
  logic [31:0]       s_axil_wdata = '0;
`ifdef MENSHEN_AXIL_WSTRB_EN
  logic [3:0]        s_axil_wstrb = 4'hF;
`endif
  logic              s_axil_bvalid, s_axil_bready = 1'b1;
  logic [1:0]        s_axil_bresp;
  logic              s_axil_arvalid = 1'b0, s_axil_arready;
  logic [31:0]       s_axil_araddr = '0;
  logic              s_axil_rvalid, s_axil_rready = 1'b1;
  logic [31:0]       s_axil_rdata;
  logic [1:0]        s_axil_rresp;
  logic [NC*32-1:0]  ctrl_regs;
  logic [NC-1:0]     ctrl_wr_pulse;
  logic [NS*32-1:0]  stat_in = '0;

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] exp_ctrl [NC];

  always #5 axil_aclk = ~axil_aclk;

  menshen_axil_regs dut (
    .axil_aclk(axil_aclk), .axil_aresetn(axil_aresetn),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready), .s_axil_awaddr(s_axil_awaddr),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_wdata(s_axil_wdata),
`ifdef MENSHEN_AXIL_WSTRB_EN
    .s_axil_wstrb(s_axil_wstrb),
`endif
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_bresp(s_axil_bresp),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready), .s_axil_araddr(s_axil_araddr),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready), .s_axil_rdata(s_axil_rdata),
    .s_axil_rresp(s_axil_rresp), .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse),
    .stat_in(stat_in)
  );

  task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NC*32-1:0] exp_flat();
    logic [NC*32-1:0] f;
    for (int i = 0; i < NC; i++) f[i*32 +: 32] = exp_ctrl[i];
    return f;
  endfunction

  // Called on a negedge; returns on the negedge after the response has been consumed (bready=1).
  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                            output logic bv, output logic [1:0] resp, output logic [NC-1:0] pulse);
    int  n;
    logic aw_fire, w_fire;
    s_axil_awaddr = addr; s_axil_wdata = data;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    n = 0;
    while ((s_axil_awvalid || s_axil_wvalid) && n < 20) begin
      #1;
      aw_fire = s_axil_awvalid && s_axil_awready;
      w_fire  = s_axil_wvalid && s_axil_wready;
      @(negedge axil_aclk);
      if (aw_fire) s_axil_awvalid = 1'b0;
      if (w_fire)  s_axil_wvalid  = 1'b0;
      n++;
    end
    check_val("wr_accept", {s_axil_awvalid, s_axil_wvalid}, 2'b00);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    bv = s_axil_bvalid; resp = s_axil_bresp; pulse = ctrl_wr_pulse;
    @(negedge axil_aclk);
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic rv,
                           output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic fire;
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    n = 0;
    while (s_axil_arvalid && n < 20) begin
      #1;
      fire = s_axil_arready;
      @(negedge axil_aclk);
      if (fire) s_axil_arvalid = 1'b0;
      n++;
    end
    check_val("rd_accept", s_axil_arvalid, 1'b0);
    s_axil_arvalid = 1'b0;
    rv = s_axil_rvalid; data = s_axil_rdata; resp = s_axil_rresp;
    @(negedge axil_aclk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic          bv, rv;
    logic [1:0]    resp;
    logic [31:0]   data;
    logic [NC-1:0] pulse;
    for (int i = 0; i < NC; i++) exp_ctrl[i] = '0;
    stat_in = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1234_5678};

    // Reset state
    repeat (3) @(negedge axil_aclk);
    check_val("rst_awready", s_axil_awready, 1'b0);
    check_val("rst_arready", s_axil_arready, 1'b0);
    check_val("rst_valids", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
    check_val("rst_resp_data", {s_axil_bresp, s_axil_rresp, s_axil_rdata}, '0);
    check_val("rst_ctrl", ctrl_regs, exp_flat());
    check_val("rst_pulse", ctrl_wr_pulse, '0);
    axil_aresetn = 1'b1;
    @(negedge axil_aclk);
    check_val("idle_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

    // Same-cycle AW+W to reg 0
    axil_write(32'h1000, 32'h1, bv, resp, pulse);
    exp_ctrl[0] = 32'h1;
    check_val("w0_bvalid", bv, 1'b1);
    check_val("w0_bresp", resp, 2'b00);
    check_val("w0_pulse", pulse, 8'h01);
    check_val("w0_ctrl", ctrl_regs, exp_flat());
    check_val("w0_pulse_gone", ctrl_wr_pulse, 8'h00);
    check_val("w0_bvalid_gone", s_axil_bvalid, 1'b0);

    // W three cycles ahead of AW, response held off for 5 cycles
    s_axil_bready = 1'b0;
    s_axil_wdata = 32'hDEAD_BEEF; s_axil_wvalid = 1'b1;
    #1 check_val("w7_wready", s_axil_wready, 1'b1);
    @(negedge axil_aclk); s_axil_wvalid = 1'b0;
    repeat (2) @(negedge axil_aclk);
    check_val("w7_no_early_commit", {s_axil_bvalid, ctrl_regs}, {1'b0, exp_flat()});
    s_axil_awaddr = 32'h101C; s_axil_awvalid = 1'b1;
    #1 check_val("w7_awready", s_axil_awready, 1'b1);
    @(negedge axil_aclk); s_axil_awvalid = 1'b0;
    exp_ctrl[7] = 32'hDEAD_BEEF;
    check_val("w7_ctrl", ctrl_regs, exp_flat());
    check_val("w7_pulse", ctrl_wr_pulse, 8'h80);
    for (int k = 0; k < 5; k++) begin
      check_val($sformatf("w7_bhold%0d", k), {s_axil_bvalid, s_axil_bresp}, 3'b100);
      check_val($sformatf("w7_noready%0d", k), {s_axil_awready, s_axil_wready}, 2'b00);
      @(negedge axil_aclk);
    end
    s_axil_bready = 1'b1;
    @(negedge axil_aclk);
    check_val("w7_bdone", s_axil_bvalid, 1'b0);

    // Status reads and rejected status write
    axil_read(32'h1020, rv, data, resp);
    check_val("stat0_rvalid", rv, 1'b1);
    check_val("stat0_rdata", data, 32'h1234_5678);
    check_val("stat0_rresp", resp, 2'b00);
    axil_read(32'h102E, rv, data, resp);
    check_val("stat3_rdata", {resp, data}, {2'b00, 32'h4444_4444});
    axil_write(32'h1020, 32'hFFFF_FFFF, bv, resp, pulse);
    check_val("wstat_bresp", {bv, resp}, 3'b110);
    check_val("wstat_pulse", pulse, 8'h00);
    check_val("wstat_ctrl", ctrl_regs, exp_flat());
    axil_read(32'h1020, rv, data, resp);
    check_val("stat0_after_wr", data, 32'h1234_5678);

    // Unmapped boundaries
    axil_read(32'h0FFC, rv, data, resp);
    check_val("rd_below", {rv, resp, data}, {1'b1, 2'b10, 32'h0});
    axil_read(32'h1030, rv, data, resp);
    check_val("rd_above", {rv, resp, data}, {1'b1, 2'b10, 32'h0});
    axil_write(32'h2000, 32'h5555_5555, bv, resp, pulse);
    check_val("wr_unmapped", {bv, resp, pulse}, {1'b1, 2'b10, 8'h00});
    check_val("wr_unmapped_ctrl", ctrl_regs, exp_flat());
    axil_read(32'h1000, rv, data, resp);
    check_val("rd_ctrl0", {resp, data}, {2'b00, 32'h1});

    // Read handshaking on the commit edge sees the old value
    s_axil_awaddr = 32'h1004; s_axil_wdata = 32'hA5A5_A5A5; s_axil_araddr = 32'h1004;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
    #1 check_val("race_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    @(negedge axil_aclk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    exp_ctrl[1] = 32'hA5A5_A5A5;
    check_val("race_b", {s_axil_bvalid, s_axil_bresp}, 3'b100);
    check_val("race_r_old", {s_axil_rvalid, s_axil_rresp, s_axil_rdata}, {1'b1, 2'b00, 32'h0});
    check_val("race_ctrl", ctrl_regs, exp_flat());
    @(negedge axil_aclk);
    axil_read(32'h1004, rv, data, resp);
    check_val("race_r_new", {rv, data}, {1'b1, 32'hA5A5_A5A5});
`ifdef MENSHEN_AXIL_WSTRB_EN
    s_axil_wstrb = 4'b0010;
    axil_write(32'h1004, 32'hFFFF_FFFF, bv, resp, pulse);
    exp_ctrl[1] = 32'hA5A5_FFA5;
    check_val("strb_b", {bv, resp, pulse}, {1'b1, 2'b00, 8'h02});
    check_val("strb_ctrl", ctrl_regs, exp_flat());
    s_axil_wstrb = 4'b0000;
    axil_write(32'h1004, 32'h0, bv, resp, pulse);
    check_val("strb0_b", {bv, resp, pulse}, {1'b1, 2'b00, 8'h02});
    check_val("strb0_ctrl", ctrl_regs, exp_flat());
    s_axil_wstrb = 4'hF;
`endif

    // Reset with AW parked and W never sent
    s_axil_awaddr = 32'h1008; s_axil_awvalid = 1'b1;
    #1 check_val("rst_mid_awready", s_axil_awready, 1'b1);
    @(negedge axil_aclk); s_axil_awvalid = 1'b0;
    axil_aresetn = 1'b0;
    for (int i = 0; i < NC; i++) exp_ctrl[i] = '0;
    @(negedge axil_aclk);
    check_val("rst_mid_ctrl", ctrl_regs, exp_flat());
    axil_aresetn = 1'b1;
    s_axil_wdata = 32'h7777_7777; s_axil_wvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge axil_aclk);
      s_axil_wvalid = 1'b0;
      check_val($sformatf("rst_no_b%0d", k), {s_axil_bvalid, ctrl_regs}, {1'b0, exp_flat()});
    end
    axil_write(32'h1008, 32'h0BAD_F00D, bv, resp, pulse);
    exp_ctrl[2] = 32'h0BAD_F00D;
    check_val("fresh_b", {bv, resp, pulse}, {1'b1, 2'b00, 8'h04});
    check_val("fresh_ctrl", ctrl_regs, exp_flat());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
